// File: rtl/puneh_bus_pkg.sv
// Shared definitions for the Puneh memory-side responder.
//   ld_state_e      : program loader FSM state encoding
//   DATA_W          : bus / RAM word width
//   IO_ADDR_DEFAULT : default bus address of the memory-mapped output register
package puneh_bus_pkg;

  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] IO_ADDR_DEFAULT = 16'hFFFF;

  typedef enum logic [1:0] {
    LD_IDLE = 2'd0,
    LD_HI   = 2'd1,
    LD_LO   = 2'd2,
    LD_DONE = 2'd3
  } ld_state_e;

endpackage

// File: rtl/puneh_mem_responder_if.sv
// CPU-side memory bus of the Puneh CPU.
//   readMEM / writeMEM : access strobes, one access per cycle
//   mem_addr           : 16-bit word address
//   mem_wdata          : write data, taken at the clock edge of a write
//   mem_rdata          : read data, combinational from the address/strobes
// master = CPU, slave = memory responder.
interface puneh_mem_responder_if;
  import puneh_bus_pkg::*;

  logic              readMEM;
  logic              writeMEM;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output readMEM,
    output writeMEM,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  readMEM,
    input  writeMEM,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/puneh_ram.sv
// Single-port word RAM: asynchronous read, synchronous write, no reset.
//   clk   : clock
//   we    : write enable, wdata stored at addr on the rising edge
//   addr  : word index (shared by read and write)
//   wdata : write data
//   rdata : read data, combinational from addr
module puneh_ram
  import puneh_bus_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/puneh_mem_responder.sv
// Memory-side responder for the Puneh CPU bus.
// Serves CPU reads/writes from a word RAM, decodes one output register at
// IO_ADDR, and contains a byte-stream program loader that fills RAM from
// address 0 while holding the CPU in reset.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   bus          : CPU bus (slave side), see puneh_mem_responder_if
//   io_in        : value returned on a read of IO_ADDR
//   io_out       : last value written to IO_ADDR
//   io_strobe    : one-cycle pulse the cycle after each IO_ADDR write
//   ld_start     : begin a load (only acted on in IDLE), ld_len captured then
//   ld_len       : number of 16-bit words to load
//   ld_valid/ld_ready/ld_byte : loader byte stream, high byte of a word first
//   ld_done      : one-cycle pulse when a load completes
//   cpu_hold     : high while the loader owns the RAM; drives CPU reset
//   bus_err      : sticky error flag, cleared only by rst
//   dbg_state    : current loader FSM state
//
// Loader handshake: a byte is transferred on every rising clock edge where
// ld_valid and ld_ready are both high; ld_valid may be held low for any
// number of cycles and the loader simply waits.
module puneh_mem_responder
  import puneh_bus_pkg::*;
#(
  parameter int                ADDR_W  = 8,
  parameter logic [DATA_W-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  puneh_mem_responder_if.slave bus,
  input  logic [DATA_W-1:0] io_in,
  output logic [DATA_W-1:0] io_out,
  output logic              io_strobe,
  input  logic              ld_start,
  input  logic [DATA_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              cpu_hold,
  output logic              bus_err,
  output ld_state_e         dbg_state
);

  ld_state_e         state_q, state_d;
  logic [DATA_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [DATA_W-1:0] io_out_q, io_out_d;
  logic              io_strobe_q, io_strobe_d;
  logic              bus_err_q, bus_err_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rdata_c;

  logic cpu_is_io;
  logic cpu_in_range;
  logic ptr_in_range;

  // IO_ADDR is tested first so it wins even if it were placed inside RAM.
  assign cpu_is_io    = (bus.mem_addr == IO_ADDR);
  assign cpu_in_range = (bus.mem_addr[DATA_W-1:ADDR_W] == '0);
  assign ptr_in_range = (ptr_q[DATA_W-1:ADDR_W] == '0);

  puneh_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= LD_IDLE;
      ptr_q       <= '0;
      len_q       <= '0;
      hi_q        <= '0;
      io_out_q    <= '0;
      io_strobe_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      len_q       <= len_d;
      hi_q        <= hi_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
      bus_err_q   <= bus_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    len_d       = len_q;
    hi_d        = hi_q;
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    bus_err_d   = bus_err_q;
    ram_we      = 1'b0;
    ram_addr    = bus.mem_addr[ADDR_W-1:0];
    ram_wdata   = bus.mem_wdata;
    rdata_c     = '0;
    ld_ready    = 1'b0;
    ld_done     = 1'b0;
    cpu_hold    = 1'b0;

    unique case (state_q)
      LD_IDLE: begin
        // CPU owns the RAM port only in IDLE.
        if (bus.readMEM && !bus.writeMEM) begin
          if (cpu_is_io) begin
            rdata_c = io_in;
          end else if (cpu_in_range) begin
            rdata_c = ram_rdata;
          end
        end
        if (bus.writeMEM) begin
          if (cpu_is_io) begin
            io_out_d    = bus.mem_wdata;
            io_strobe_d = 1'b1;
          end else if (cpu_in_range) begin
            ram_we = 1'b1;
          end
        end
        // Unmapped access, or a simultaneous read+write (the write still
        // goes ahead, the read returns 0).
        if ((bus.readMEM || bus.writeMEM) && !cpu_is_io && !cpu_in_range) begin
          bus_err_d = 1'b1;
        end
        if (bus.readMEM && bus.writeMEM) begin
          bus_err_d = 1'b1;
        end

        if (ld_start) begin
          if (ld_len == '0) begin
            state_d = LD_DONE;
          end else begin
            state_d = LD_HI;
            ptr_d   = '0;
            len_d   = ld_len;
          end
        end
      end

      LD_HI: begin
        cpu_hold = 1'b1;
        ld_ready = 1'b1;
        ram_addr = ptr_q[ADDR_W-1:0];
        if (ld_valid) begin
          hi_d    = ld_byte;
          state_d = LD_LO;
        end
      end

      LD_LO: begin
        cpu_hold  = 1'b1;
        ld_ready  = 1'b1;
        ram_addr  = ptr_q[ADDR_W-1:0];
        ram_wdata = {hi_q, ld_byte};
        if (ld_valid) begin
          // Words beyond DEPTH are dropped but the stream is still consumed
          // so the load terminates normally.
          if (ptr_in_range) begin
            ram_we = 1'b1;
          end else begin
            bus_err_d = 1'b1;
          end
          ptr_d   = ptr_q + 1'b1;
          state_d = (ptr_q == len_q - 1'b1) ? LD_DONE : LD_HI;
        end
      end

      LD_DONE: begin
        cpu_hold = 1'b1;
        ld_done  = 1'b1;
        state_d  = LD_IDLE;
      end

      default: begin
        state_d = LD_IDLE;
      end
    endcase
  end

  assign bus.mem_rdata = rdata_c;
  assign io_out        = io_out_q;
  assign io_strobe     = io_strobe_q;
  assign bus_err       = bus_err_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/puneh_mem_responder.md
Name: puneh_mem_responder

Overview:
- Memory-side responder for the Puneh CPU bus. Answers the CPU's readMEM/writeMEM accesses from a word RAM, with combinational read data in the same cycle and a synchronous write.
- Decodes one memory-mapped output register at IO_ADDR.
- Contains a byte-stream program loader FSM that fills RAM from address 0 while holding the CPU in reset through cpu_hold.

Parameters:
- ADDR_W, 8, RAM index width; DEPTH = 2**ADDR_W words of 16 bits.
- IO_ADDR, 16'hFFFF, bus address of the I/O register.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- readMEM  in  1  CPU read request
- writeMEM  in  1  CPU write request
- mem_addr  in  16  CPU address bus
- mem_wdata  in  16  CPU write data
- mem_rdata  out  16  read data returned to CPU, combinational
- io_in  in  16  value returned on a read of IO_ADDR
- io_out  out  16  last value written to IO_ADDR
- io_strobe  out  1  one-cycle pulse, the cycle after an IO_ADDR write
- ld_start  in  1  start program load; sampled only in IDLE
- ld_len  in  16  number of words to load; captured on ld_start
- ld_valid  in  1  loader byte valid
- ld_byte  in  8  loader byte; high byte of each word first
- ld_ready  out  1  loader can accept a byte
- ld_done  out  1  one-cycle pulse when a load completes
- cpu_hold  out  1  high while loading; drives CPU reset
- bus_err  out  1  sticky error flag; cleared only by rst

Behaviour:
Reset (synchronous):
- FSM goes to IDLE; io_out=0, io_strobe=0, ld_done=0, bus_err=0, word pointer=0, hi-byte register=0.
- RAM contents are not reset.
- cpu_hold=0 and ld_ready=0 after reset.

CPU reads (combinational, cpu_hold=0):
- readMEM=1 with mem_addr==IO_ADDR: mem_rdata=io_in.
- readMEM=1 with mem_addr[15:ADDR_W]==0: mem_rdata=RAM[mem_addr[ADDR_W-1:0]].
- Any other case: mem_rdata=16'h0000.

CPU writes (take effect at the clock edge, cpu_hold=0):
- writeMEM=1 with an in-range address: RAM updated.
- writeMEM=1 with mem_addr==IO_ADDR: io_out<=mem_wdata; io_strobe=1 in the next cycle only.
- Back-to-back IO writes keep io_strobe high for consecutive cycles.

Error conditions:
- An access to an address that is neither in range nor IO_ADDR: read returns 0, write is dropped, bus_err<=1.
- readMEM and writeMEM high together: the write is performed, mem_rdata=0, bus_err<=1.
- While cpu_hold=1, all CPU requests are ignored (mem_rdata=0, no writes, bus_err unchanged).

Loader FSM states: IDLE, LOAD_HI, LOAD_LO, DONE.
- IDLE, on ld_start:
  - ld_len==0: go to DONE.
  - otherwise: go to LOAD_HI; pointer<=0; captured length<=ld_len.
- LOAD_HI:
  - ld_ready=1.
  - On ld_valid: latch the byte into hi; go to LOAD_LO.
  - Without ld_valid: stay in LOAD_HI, with no timeout.
- LOAD_LO:
  - ld_ready=1.
  - On ld_valid: RAM[pointer]<={hi, ld_byte}; pointer increments.
  - If pointer==len-1, go to DONE; otherwise go to LOAD_HI.
- DONE: ld_done=1 for one cycle, then IDLE.
- cpu_hold=1 in LOAD_HI, LOAD_LO and DONE, and drops the cycle after DONE.
- ld_start outside IDLE is ignored.
- A loader write that falls outside DEPTH (len > DEPTH): word dropped, bus_err<=1, load continues to completion.
- rst asserted mid-load returns the FSM to IDLE immediately; RAM words already written are kept.

Decomposition:
- Shared package puneh_bus_pkg holds:
  - the loader state enum;
  - IO_ADDR default;
  - the data width constant (16).
- One sub-module, puneh_ram: single-port RAM with asynchronous read and synchronous write. The responder muxes its write port between the CPU and the loader, with the loader owning the port whenever cpu_hold=1.

Test Plan:
- Reset, then ld_start with ld_len=2 and bytes 12,34,AB,CD -> RAM[0]=1234, RAM[1]=ABCD; ld_done pulses once; cpu_hold drops the next cycle; ld_ready=0 in IDLE.
- Write 16'h5A5A to address 3, then read address 3 -> mem_rdata=5A5A in the read cycle; bus_err=0.
- Write 16'h00FF to IO_ADDR -> io_out=00FF and io_strobe=1 for exactly one cycle; read IO_ADDR with io_in=BEEF -> mem_rdata=BEEF.
- Read address 16'h0100 (ADDR_W=8) -> mem_rdata=0000 and bus_err=1; write to the same address leaves RAM unchanged.
- ld_len=0 -> DONE on the next cycle, ld_done pulse, no RAM write; then ld_start during LOAD_HI of a second load is ignored (pointer unaffected).
- Assert rst after 3 of 4 bytes of a 2-word load -> FSM in IDLE, cpu_hold=0, RAM[0] keeps the first word, RAM[1] unchanged.
